// File: rtl/sr_ff_bank.sv
// Bank of clocked multi-input SR flip-flops with a run-time S=R=1 policy and per-channel conflict counters.
// Latency: 1 cycle from s/r/mode/en to q and conflict; no backpressure, an update is taken on every enabled edge.
module sr_ff_bank #(
    parameter int WIDTH = 8,
    parameter int NSET  = 2,
    parameter int NRST  = 2,
    parameter int CNT_W = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic [WIDTH*NSET-1:0]    s,
    input  logic [WIDTH*NRST-1:0]    r,
    input  logic                     clr_cnt,
    output logic [WIDTH-1:0]         q,
    output logic [WIDTH-1:0]         qbar,
    output logic [WIDTH-1:0]         conflict,
    output logic [WIDTH*CNT_W-1:0]   conflict_cnt,
    output logic [WIDTH-1:0]         cnt_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [1:0] MODE_RST = 2'b00;
    localparam logic [1:0] MODE_SET = 2'b01;
    localparam logic [1:0] MODE_HLD = 2'b10;

    // qbar is derived so it can never disagree with q
    assign qbar = ~q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic             set_any;
        logic             rst_any;
        logic             both;
        logic             q_nxt;
        logic             q_r;
        logic             conf_r;
        logic             sat_r;
        logic [CNT_W-1:0] cnt_r;

        assign set_any = |s[i*NSET +: NSET];
        assign rst_any = |r[i*NRST +: NRST];
        assign both    = set_any & rst_any;

        always_comb begin
            q_nxt = q_r;
            if (both) begin
                case (mode)
                    MODE_RST: q_nxt = 1'b0;
                    MODE_SET: q_nxt = 1'b1;
                    MODE_HLD: q_nxt = q_r;
                    default:  q_nxt = ~q_r;
                endcase
            end else if (set_any) begin
                q_nxt = 1'b1;
            end else if (rst_any) begin
                q_nxt = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                q_r    <= RESET_VAL[i];
                conf_r <= 1'b0;
                cnt_r  <= '0;
                sat_r  <= 1'b0;
            end else begin
                if (en) begin
                    q_r    <= q_nxt;
                    conf_r <= both;
                end else begin
                    conf_r <= 1'b0;
                end
                // clear beats a same-edge increment
                if (clr_cnt) begin
                    cnt_r <= '0;
                    sat_r <= 1'b0;
                end else if (en && both) begin
                    if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                    if ((cnt_r == CNT_MAX) || (cnt_r == CNT_MAX - CNT_W'(1))) begin
                        sat_r <= 1'b1;
                    end
                end
            end
        end

        assign q[i]                         = q_r;
        assign conflict[i]                  = conf_r;
        assign cnt_sat[i]                   = sat_r;
        assign conflict_cnt[i*CNT_W +: CNT_W] = cnt_r;
    end

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed vector table plus random regression against a behavioural model of sr_ff_bank.
module tb_sr_ff_bank;

    localparam int WIDTH = 4;
    localparam int NSET  = 2;
    localparam int NRST  = 2;
    localparam int CNT_W = 2;
    localparam logic [3:0] RV = 4'b0101;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [7:0] s;
    logic [7:0] r;
    logic       clr_cnt;
    logic [3:0] q;
    logic [3:0] qbar;
    logic [3:0] conflict;
    logic [7:0] conflict_cnt;
    logic [3:0] cnt_sat;

    int n_chk  = 0;
    int n_fail = 0;

    sr_ff_bank #(
        .WIDTH(WIDTH), .NSET(NSET), .NRST(NRST), .CNT_W(CNT_W), .RESET_VAL(RV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .r(r),
        .clr_cnt(clr_cnt), .q(q), .qbar(qbar), .conflict(conflict),
        .conflict_cnt(conflict_cnt), .cnt_sat(cnt_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       clr;
        logic [1:0] mode;
        logic [7:0] s;
        logic [7:0] r;
        logic [3:0] q;
        logic [3:0] conf;
        logic [7:0] cnt;
        logic [3:0] sat;
    } vec_t;

    localparam int NVEC = 21;
    vec_t tbl [NVEC];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] eq, input logic [3:0] ec,
                             input logic [7:0] ecnt, input logic [3:0] es);
        chk({tag, ".q"},        {4'b0, q},        {4'b0, eq});
        chk({tag, ".qbar"},     {4'b0, qbar},     {4'b0, ~eq});
        chk({tag, ".conflict"}, {4'b0, conflict}, {4'b0, ec});
        chk({tag, ".cnt"},      conflict_cnt,     ecnt);
        chk({tag, ".sat"},      {4'b0, cnt_sat},  {4'b0, es});
    endtask

    // behavioural reference state
    logic [3:0] m_q;
    logic [3:0] m_conf;
    logic [3:0] m_sat;
    int         m_cnt [4];

    function automatic logic [7:0] pack_cnt();
        logic [7:0] v;
        for (int c = 0; c < 4; c++) v[c*2 +: 2] = 2'(m_cnt[c]);
        return v;
    endfunction

    task automatic model_step();
        logic S, R;
        for (int c = 0; c < 4; c++) begin
            S = s[c*2] | s[c*2+1];
            R = r[c*2] | r[c*2+1];
            if (!rst_n) begin
                m_q[c] = RV[c]; m_conf[c] = 1'b0; m_cnt[c] = 0; m_sat[c] = 1'b0;
            end else begin
                if (!en) begin
                    m_conf[c] = 1'b0;
                end else begin
                    m_conf[c] = S & R;
                    if (S && !R)      m_q[c] = 1'b1;
                    else if (!S && R) m_q[c] = 1'b0;
                    else if (S && R) begin
                        if (mode == 2'd0)      m_q[c] = 1'b0;
                        else if (mode == 2'd1) m_q[c] = 1'b1;
                        else if (mode == 2'd3) m_q[c] = !m_q[c];
                        if (m_cnt[c] < 3) m_cnt[c] = m_cnt[c] + 1;
                        if (m_cnt[c] == 3) m_sat[c] = 1'b1;
                    end
                end
                if (clr_cnt) begin
                    m_cnt[c] = 0; m_sat[c] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; mode = 2'b00; s = '0; r = '0; clr_cnt = 1'b0;

        // rst_n en clr mode s r | q conf cnt sat
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 2'd3, 8'hFF, 8'hFF, 4'b0101, 4'b0000, 8'h00, 4'b0000};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h02, 8'h04, 4'b0101, 4'b0000, 8'h00, 4'b0000};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h02, 8'h04, 4'b0101, 4'b0000, 8'h00, 4'b0000};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h40, 8'h00, 4'b0101, 4'b0000, 8'h00, 4'b0000};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h10, 8'h20, 4'b0001, 4'b0100, 8'h10, 4'b0000};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 2'd1, 8'h10, 8'h20, 4'b0101, 4'b0100, 8'h20, 4'b0000};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 2'd2, 8'h10, 8'h20, 4'b0101, 4'b0100, 8'h30, 4'b0100};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 2'd3, 8'h10, 8'h20, 4'b0001, 4'b0100, 8'h30, 4'b0100};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 2'd3, 8'h10, 8'h20, 4'b0101, 4'b0100, 8'h30, 4'b0100};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 2'd3, 8'h10, 8'h20, 4'b0001, 4'b0100, 8'h30, 4'b0100};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 2'd1, 8'h10, 8'h20, 4'b0101, 4'b0100, 8'h00, 4'b0000};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 2'd1, 8'h10, 8'h20, 4'b0101, 4'b0100, 8'h10, 4'b0000};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 2'd3, 8'hFF, 8'hFF, 4'b1010, 4'b1111, 8'h65, 4'b0000};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 2'd3, 8'hFF, 8'hFF, 4'b0101, 4'b1111, 8'hBA, 4'b0100};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 2'd3, 8'hFF, 8'hFF, 4'b0101, 4'b0000, 8'h00, 4'b0000};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 4'b0101, 4'b0000, 8'h00, 4'b0000};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 2'd0, 8'hFF, 8'h00, 4'b1111, 4'b0000, 8'h00, 4'b0000};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 2'd2, 8'hFF, 8'hFF, 4'b1111, 4'b1111, 8'h55, 4'b0000};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 2'd2, 8'hFF, 8'hFF, 4'b1111, 4'b0000, 8'h55, 4'b0000};
        tbl[19] = '{1'b1, 1'b0, 1'b1, 2'd2, 8'hFF, 8'hFF, 4'b1111, 4'b0000, 8'h00, 4'b0000};
        tbl[20] = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 8'hFF, 4'b0000, 4'b0000, 8'h00, 4'b0000};

        for (int k = 0; k < NVEC; k++) begin
            @(negedge clk);
            rst_n = tbl[k].rst_n; en = tbl[k].en; clr_cnt = tbl[k].clr;
            mode = tbl[k].mode; s = tbl[k].s; r = tbl[k].r;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", k), tbl[k].q, tbl[k].conf, tbl[k].cnt, tbl[k].sat);
        end

        // reset with random inputs, then random regression against the model
        @(negedge clk);
        rst_n = 1'b0; en = 1'($urandom); clr_cnt = 1'($urandom);
        mode = 2'($urandom); s = 8'($urandom); r = 8'($urandom);
        @(posedge clk);
        #1;
        check_all("rand_reset", RV, 4'b0000, 8'h00, 4'b0000);
        m_q = RV; m_conf = '0; m_sat = '0;
        for (int c = 0; c < 4; c++) m_cnt[c] = 0;

        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            rst_n   = ($urandom_range(0, 31) != 0);
            en      = ($urandom_range(0, 7) != 0);
            clr_cnt = ($urandom_range(0, 15) == 0);
            mode    = 2'($urandom);
            s       = 8'($urandom) & 8'($urandom);
            r       = 8'($urandom) & 8'($urandom);
            model_step();
            @(posedge clk);
            #1;
            check_all("rand", m_q, m_conf, pack_cnt(), m_sat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_ff_bank.md
# sr_ff_bank

Parametrised bank of clocked SR flip-flops: WIDTH independent channels, each with NSET set inputs and NRST reset inputs OR-combined, as in the multi-input SR latches, but registered on one clock. A run-time mode decides the S=R=1 outcome: reset-dominant, set-dominant, hold, or toggle (JK behaviour). Each channel counts forbidden-condition (S=R=1) events in a saturating counter for diagnostics. Sits between control decode logic and status/flag consumers.

## Interface

- WIDTH, 8, number of channels
- NSET, 2, set inputs per channel
- NRST, 2, reset inputs per channel
- CNT_W, 4, width of each per-channel conflict counter
- RESET_VAL, {WIDTH{1'b0}}, q value loaded at reset
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  update enable; 0 = hold everything except counter clear
- mode  in  2  conflict policy: 00 reset-dominant, 01 set-dominant, 10 hold, 11 toggle
- s  in  WIDTH*NSET  set inputs; channel i = s[i*NSET +: NSET]
- r  in  WIDTH*NRST  reset inputs; channel i = r[i*NRST +: NRST]
- clr_cnt  in  1  synchronous clear of all conflict counters and sat flags
- q  out  WIDTH  registered state
- qbar  out  WIDTH  always exactly ~q (derived from q, never independently registered)
- conflict  out  WIDTH  registered: channel saw S=R=1 with en=1 on previous edge
- conflict_cnt  out  WIDTH*CNT_W  per-channel saturating conflict counters; channel i = [i*CNT_W +: CNT_W]
- cnt_sat  out  WIDTH  sticky: channel counter reached all-ones

## Operation

- Per channel: S = |s-slice, R = |r-slice.
- en=1, per channel, next q:
  - S=0,R=0: hold.
  - S=1,R=0: 1.
  - S=0,R=1: 0.
  - S=1,R=1: mode 00 -> 0; 01 -> 1; 10 -> hold; 11 -> ~q.
- en=0: q holds, conflict <= 0, counters hold, cnt_sat holds.
- Conflict counting (en=1 and S=R=1): conflict[i] <= 1; counter increments by 1 unless already all-ones (saturates, no wrap); cnt_sat[i] <= 1 when counter becomes or is all-ones.
- en=1 and not S=R=1: conflict[i] <= 0.
- clr_cnt=1: all counters <= 0 and cnt_sat <= 0 on that edge, regardless of en; clr wins over a same-cycle increment. clr_cnt does not affect q or conflict.
- Mode is sampled on the same edge it governs; no pipelining of mode.
- Channels are fully independent; no cross-channel interaction.

## Timing

- All state updates on rising clk; 1-cycle latency from s/r/mode/en to q and conflict.
- Reset (rst_n=0 at edge): q=RESET_VAL, qbar=~RESET_VAL, conflict=0, all counters=0, cnt_sat=0. Reset overrides en, clr_cnt and all inputs; reset mid-sequence discards pending state on that edge.
- First post-reset edge with rst_n=1 applies normal rules.
- Toggle mode with S=R=1 held N cycles: q alternates every edge; counter advances every edge until saturation.
- Counter saturation: at 2^CNT_W-1, further conflicts keep value, conflict still pulses 1, cnt_sat stays 1.
- No combinational path from inputs to outputs.

## Test plan

Parameters for bench: WIDTH=4, NSET=2, NRST=2, CNT_W=2, RESET_VAL=4'b0101.
- Reset: rst_n=0 one edge with random s/r/en/clr_cnt -> q=0101, qbar=1010, conflict=0000, conflict_cnt=0, cnt_sat=0000.
- Basic set/reset via either input: en=1, ch0 s=2'b10, ch1 r=2'b01, others 0 -> next edge q=0101 (ch0=1, ch1=0, ch2 hold 1, ch3 hold 0 per RESET_VAL bits); then repeat, q unchanged; en=0 with ch3 set -> q unchanged, conflict=0000.
- Mode sweep on ch2 with S=R=1 from q[2]=1: mode 00 -> q[2]=0; 01 -> 1; 10 -> holds 1; 11 for 3 edges -> 0,1,0; conflict[2]=1 each edge, conflict_cnt ch2 = 1,2,3,3,3,3 and cnt_sat[2]=1 from third conflict.
- Saturation and clear: after ch2 saturated, clr_cnt=1 together with S=R=1 on ch2 -> counter=0, cnt_sat[2]=0, conflict[2]=1, q follows mode; next conflict edge -> counter=1.
- Reset mid-operation: toggle mode, S=R=1 on all channels for 2 edges, then rst_n=0 -> q=0101, counters 0, conflict 0000 on that edge; next edge with rst_n=1 and no inputs -> all hold.
- Random regression: 10k cycles random s/r/mode/en/clr_cnt/rst_n against a behavioural model; compare q, qbar=~q, conflict, counters, cnt_sat every edge.
